// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package rf_pkg;

  localparam int unsigned DW       = 64;
  localparam int unsigned AW       = 5;
  localparam int unsigned ZERO_REG = 31;
  localparam int unsigned NUM_REQ  = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. The override forces a specific winner when both
// inputs request. The priority pointer moves past whichever input was granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       ovr_en,
  input  logic       ovr_sel,
  output logic [1:0] gnt,
  output logic       gnt_idx,
  output logic       gnt_any
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_idx = 1'b0;
    gnt     = '0;
    if (&req) begin
      gnt_idx = ovr_en ? ovr_sel : ptr_q;
    end else begin
      gnt_idx = req[1];
    end
    gnt_any = |req;
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
    ptr_d = gnt_any ? ~gnt_idx : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between an ALU and a load-return producer,
// with one holding buffer per producer, a registered write stage and hazard lookup.
module regfile_wr_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DW       = rf_pkg::DW,
  parameter int unsigned AW       = rf_pkg::AW,
  parameter int unsigned ZERO_REG = rf_pkg::ZERO_REG,
  parameter int unsigned CW       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_data0,
  input  logic [DW-1:0] req_data1,
  output logic          rf_en,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_din,
  input  logic [AW-1:0] sa,
  input  logic [AW-1:0] sb,
  output logic          hazard_a,
  output logic          hazard_b,
  output logic [CW-1:0] commit_cnt,
  output logic [CW-1:0] drop_cnt
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } slot_t;

  slot_t [NUM_REQ-1:0] req_in, buf_q, buf_d;
  logic  [1:0]         full_q, full_d, gnt, acc, is_zero, ld, drop, remain;
  logic                gnt_idx, gnt_any, same_addr, age_q, age_d;
  logic                rf_en_q, rf_en_d;
  logic [AW-1:0]       rf_addr_q, rf_addr_d;
  logic [DW-1:0]       rf_din_q, rf_din_d;
  logic [CW-1:0]       commit_q, commit_d, drop_cnt_q, drop_cnt_d;

  assign req_in[0] = {req_addr0, req_data0};
  assign req_in[1] = {req_addr1, req_data1};
  assign is_zero   = {req_addr1 == AW'(ZERO_REG), req_addr0 == AW'(ZERO_REG)};

  // Same-address contention is resolved by age so the later write lands last.
  assign same_addr = (&full_q) && (buf_q[0].addr == buf_q[1].addr);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (full_q),
    .ovr_en  (same_addr),
    .ovr_sel (age_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign req_ready = ~full_q | gnt;
  assign acc       = req_valid & req_ready;

  always_comb begin
    ld     = acc & ~is_zero;
    drop   = acc & is_zero;
    remain = full_q & ~gnt;
    full_d = remain | ld;
    buf_d  = buf_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ld[i]) begin
        buf_d[i] = req_in[i];
      end
    end
    // age_q names the older buffer; it only matters while both are full.
    age_d = age_q;
    if (ld == 2'b11) begin
      age_d = 1'b0;
    end else if (ld[0] && remain[1]) begin
      age_d = 1'b1;
    end else if (ld[1] && remain[0]) begin
      age_d = 1'b0;
    end
    rf_en_d   = gnt_any;
    rf_addr_d = gnt_any ? buf_q[gnt_idx].addr : rf_addr_q;
    rf_din_d  = gnt_any ? buf_q[gnt_idx].data : rf_din_q;
    commit_d   = commit_q + CW'(rf_en_q);
    drop_cnt_d = drop_cnt_q + CW'(drop[0]) + CW'(drop[1]);
  end

  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (full_q[i] && buf_q[i].addr == sa) hazard_a = 1'b1;
      if (full_q[i] && buf_q[i].addr == sb) hazard_b = 1'b1;
    end
    if (rf_en_q && rf_addr_q == sa) hazard_a = 1'b1;
    if (rf_en_q && rf_addr_q == sb) hazard_b = 1'b1;
    if (sa == AW'(ZERO_REG)) hazard_a = 1'b0;
    if (sb == AW'(ZERO_REG)) hazard_b = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= '0;
      buf_q      <= '0;
      age_q      <= 1'b0;
      rf_en_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_din_q   <= '0;
      commit_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      full_q     <= full_d;
      buf_q      <= buf_d;
      age_q      <= age_d;
      rf_en_q    <= rf_en_d;
      rf_addr_q  <= rf_addr_d;
      rf_din_q   <= rf_din_d;
      commit_q   <= commit_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rf_en      = rf_en_q;
  assign rf_addr    = rf_addr_q;
  assign rf_din     = rf_din_q;
  assign commit_cnt = commit_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port (en/addr/din) between two producers: requester 0 (ALU result) and requester 1 (memory load return).
- Each requester has a one-entry holding buffer; a round-robin arbiter picks one buffer per cycle and drives a registered write stage toward the register file.
- Tracks pending writes so the operand-read logic can detect hazards on the two read-select addresses.
- Writes to register 31, the hard-wired zero register, are accepted and discarded.

Parameters:
- DW, 64, data width of register file words.
- AW, 5, register address width.
- ZERO_REG, 31, address whose writes are dropped.
- CW, 16, width of the commit and drop counters.

Ports:
- clk, input, 1, sole clock; all state updates on posedge.
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 2, per-requester write request.
- req_ready, output, 2, per-requester accept; transfer when valid && ready at posedge.
- req_addr0 / req_addr1, input, AW each, destination register.
- req_data0 / req_data1, input, DW each, write data.
- rf_en, output, 1, register-file write enable (registered).
- rf_addr, output, AW, register-file write address (registered).
- rf_din, output, DW, register-file write data (registered).
- sa / sb, input, AW each, current read-select addresses.
- hazard_a / hazard_b, output, 1 each, combinational: sa/sb has a pending write.
- commit_cnt, output, CW, wrapping count of rf_en pulses.
- drop_cnt, output, CW, wrapping count of accepted ZERO_REG writes.

Behaviour:
- Reset (async on rst_n low, released synchronously by the next posedge):
  - both buffers empty; rf_en=0, rf_addr=0, rf_din=0.
  - commit_cnt=0, drop_cnt=0.
  - round-robin pointer = requester 0 has priority; age bit = 0.
  - Reset mid-operation discards all buffered and staged writes.
- req_ready[i] = buffer i empty OR buffer i granted this cycle; allows back-to-back acceptance.
- Acceptance with addr == ZERO_REG:
  - buffer i is not loaded; drop_cnt increments at that edge.
  - If both requesters drop on the same edge, drop_cnt increments by 2.
- Arbitration each cycle among full buffers:
  - Only one full: grant it.
  - Both full, different addresses: grant the pointer-priority requester. After any grant the pointer moves to the other requester.
  - Both full, same address: grant the older buffer regardless of pointer, so the later write lands last.
    - Age bit records which buffer loaded first.
    - Same-edge loads: requester 0 is older.
    - The pointer still toggles after this grant.
- Grant edge:
  - rf_en <= 1, rf_addr/rf_din <= granted buffer contents.
  - Granted buffer empties; it may reload on the same edge.
  - commit_cnt increments on every cycle rf_en is 1.
- No grant: rf_en <= 0; rf_addr/rf_din hold their values.
- Latency: accept at edge T, rf_en high during cycle T+1..T+2, register file captures at edge T+2.
- Throughput: one write per cycle total. A single requester can sustain one accept per cycle.
- pending[n] is 1 when either full buffer, or the rf stage with rf_en=1, targets n. pending[ZERO_REG] is always 0.
- hazard_a = pending[sa]; hazard_b = pending[sb]. These are pure combinational, with no register.
- Counters wrap from 2^CW-1 to 0 without any flag.

Decomposition:
- Shared package rf_pkg:
  - constants DW, AW, ZERO_REG, NUM_REQ=2.
  - typedef wr_req_t {addr[AW], data[DW]}.
- One natural sub-module: rr_arb2, a two-input round-robin grant with an override input for the same-address age rule.
- Buffers, the write stage, the scoreboard and the counters stay in the top module.

Test Plan:
- Reset: rst_n low mid-stream with both buffers full -> rf_en=0, req_ready=2'b11, commit_cnt=0 immediately, no later rf_en.
- Single write: req0 valid, addr=5, data=0xDEAD_BEEF at edge T -> rf_en=1, rf_addr=5, rf_din=0xDEADBEEF after edge T+1. hazard_a=1 with sa=5 during T..T+2, then 0.
- Contention: both valid every cycle, addrs 3 and 7, for 6 cycles -> rf_addr alternates 3,7,3,7,... starting with 3. commit_cnt=6 after the 6th pulse.
- Same address: at edge T load req1 addr=9 data=0x1, at edge T+1 load req0 addr=9 data=0x2 with the pointer favouring req0 -> commits in order 0x1 then 0x2.
- Zero register: req0 addr=31, req1 addr=31 on the same edge -> no rf_en, drop_cnt=2, hazard_a=0 for sa=31.
- Wrap: preload 0xFFFF commits via a sequence -> next commit gives commit_cnt=0.
